// File: rtl/background_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : background_pattern_gen
// Description : Background pixel source for a video mixer. Tracks the next
//               pixel position and keeps a registered RGB565 pixel ready for
//               it: solid colour, colour bars, checkerboard or a gradient
//               that scrolls from frame to frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module background_pattern_gen #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [15:0] SOLID_COLOR = 16'h001F,
    parameter int          CHK_BIT     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic        i_pixel_valid,
    input  logic [1:0]  i_mode,
    output logic [15:0] bg_data,
    output logic        o_frame_done,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [9:0] c_X_LAST       = 10'(H_ACTIVE - 1);
    localparam logic [8:0] c_Y_LAST       = 9'(V_ACTIVE - 1);
    localparam logic [9:0] c_BAR_PIX_LAST = 10'(H_ACTIVE / 8 - 1);

    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [9:0]  bar_pix_q, bar_pix_d;
    logic [2:0]  bar_q, bar_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [15:0] bg_q, bg_d;
    logic [4:0]  w_grad_r;

    // Next position, latched mode, frame counter and frame-done pulse
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bar_pix_d = bar_pix_q;
        bar_d     = bar_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (i_frame_start) begin
            // A new frame wins over a coincident valid: restart at (0,0)
            x_d       = '0;
            y_d       = '0;
            bar_pix_d = '0;
            bar_d     = '0;
            mode_d    = i_mode;
            cnt_d     = cnt_q + 8'd1;
        end else if (i_pixel_valid) begin
            done_d = (x_q == c_X_LAST) && (y_q == c_Y_LAST);
            if (x_q == c_X_LAST) begin
                x_d       = '0;
                bar_pix_d = '0;
                bar_d     = '0;
                y_d       = (y_q == c_Y_LAST) ? 9'd0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
                // Bar index tracked incrementally so no divider is needed
                if (bar_pix_q == c_BAR_PIX_LAST) begin
                    bar_pix_d = '0;
                    bar_d     = bar_q + 3'd1;
                end else begin
                    bar_pix_d = bar_pix_q + 10'd1;
                end
            end
        end
    end

    // Pattern for the next position, so the registered pixel is ready early
    always_comb begin
        w_grad_r = x_d[8:4] + cnt_d[4:0];
        bg_d     = SOLID_COLOR;
        case (mode_d)
            2'd0: bg_d = SOLID_COLOR;
            2'd1: begin
                case (bar_d)
                    3'd0:    bg_d = 16'hFFFF;
                    3'd1:    bg_d = 16'hFFE0;
                    3'd2:    bg_d = 16'h07FF;
                    3'd3:    bg_d = 16'h07E0;
                    3'd4:    bg_d = 16'hF81F;
                    3'd5:    bg_d = 16'hF800;
                    3'd6:    bg_d = 16'h001F;
                    default: bg_d = 16'h0000;
                endcase
            end
            2'd2:    bg_d = (x_d[CHK_BIT] ^ y_d[CHK_BIT]) ? 16'hFFFF : 16'h0000;
            default: bg_d = {w_grad_r, y_d[8:3], 5'h10};
        endcase
    end

    // State registers; reset abandons any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            bar_pix_q <= '0;
            bar_q     <= '0;
            mode_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bg_q      <= SOLID_COLOR;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bar_pix_q <= bar_pix_d;
            bar_q     <= bar_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            bg_q      <= bg_d;
        end
    end

    assign bg_data      = bg_q;
    assign o_frame_done = done_q;
    assign o_frame_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_background_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_background_pattern_gen
// Description : Scoreboard bench for background_pattern_gen on a 16x4 frame
//               with a 2-pixel checker tile.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_background_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_frame_start = 1'b0;
    logic        i_pixel_valid = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [15:0] bg_data;
    logic        o_frame_done;
    logic [7:0]  o_frame_cnt;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  exp_cnt;
    logic [15:0] exp_px;

    background_pattern_gen #(
        .H_ACTIVE   (16),
        .V_ACTIVE   (4),
        .SOLID_COLOR(16'h001F),
        .CHK_BIT    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_start(i_frame_start),
        .i_pixel_valid(i_pixel_valid),
        .i_mode       (i_mode),
        .bg_data      (bg_data),
        .o_frame_done (o_frame_done),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; a consumed pixel queues its expected colour
    task automatic step(input logic fs, input logic v, input logic [15:0] exp);
        @(posedge clk);
        #1;
        i_frame_start = fs;
        i_pixel_valid = v;
        if (v && !fs) exp_q.push_back(exp);
    endtask

    // Monitor: every consumed pixel is compared against the scoreboard
    always @(negedge clk) begin
        if (o_frame_done) done_cnt++;
        if (!rst && i_pixel_valid && !i_frame_start) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pixel: got %h expected nothing (queue empty)", bg_data);
            end else begin
                chk("pixel", bg_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bg", bg_data, 16'h001F);
        chk("rst_cnt", {8'd0, o_frame_cnt}, 16'd0);
        chk("rst_done", {15'd0, o_frame_done}, 16'd0);

        // Mode 0 holds until the first frame start regardless of i_mode
        i_mode = 2'd2;
        repeat (3) step(1'b0, 1'b1, 16'h001F);

        // Colour bars; i_mode changes after row 0 but must not take effect
        i_mode = 2'd1;
        step(1'b1, 1'b0, 16'h0);
        for (int x = 0; x < 16; x++) step(1'b0, 1'b1, bars[x / 2]);
        i_mode = 2'd3;
        for (int p = 16; p < 64; p++) step(1'b0, 1'b1, bars[(p % 16) / 2]);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("bars_done", {15'd0, o_frame_done}, 16'd1);
        chk("bars_cnt", {8'd0, o_frame_cnt}, 16'd1);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("bars_done_end", {15'd0, o_frame_done}, 16'd0);

        // Gradient of latched mode 3: R = frame count 2 -> 0x1010
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("grad_first", bg_data, 16'h1010);
        chk("grad_cnt", {8'd0, o_frame_cnt}, 16'd2);

        // Checkerboard with random idle gaps
        i_mode = 2'd2;
        step(1'b1, 1'b0, 16'h0);
        for (int p = 0; p < 64; p++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 16'h0);
            step(1'b0, 1'b1, ((((p % 16) >> 1) ^ ((p / 16) >> 1)) & 1) != 0 ? 16'hFFFF : 16'h0000);
        end
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("chk_done", {15'd0, o_frame_done}, 16'd1);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("chk_done_end", {15'd0, o_frame_done}, 16'd0);
        chk("chk_done_total", 16'(done_cnt), 16'd2);
        // Position wrapped to (0,0): 0000, 0000, FFFF
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'hFFFF);

        // Advance to (5,2), then frame start collides with a valid
        for (int p = 3; p < 37; p++)
            step(1'b0, 1'b1, ((((p % 16) >> 1) ^ ((p / 16) >> 1)) & 1) != 0 ? 16'hFFFF : 16'h0000);
        i_mode = 2'd1;
        step(1'b1, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("coll_cnt", {8'd0, o_frame_cnt}, 16'd4);
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'hFFE0);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("coll_no_done", 16'(done_cnt), 16'd2);

        // 252 more frame starts wrap the counter; R follows it and wraps 31 -> 0
        i_mode  = 2'd3;
        exp_cnt = 8'd4;
        for (int i = 0; i < 252; i++) begin
            step(1'b1, 1'b0, 16'h0);
            step(1'b0, 1'b0, 16'h0);
            @(negedge clk);
            exp_cnt = exp_cnt + 8'd1;
            exp_px  = {exp_cnt[4:0], 6'd0, 5'h10};
            chk("wrap_cnt", {8'd0, o_frame_cnt}, {8'd0, exp_cnt});
            chk("wrap_grad", bg_data, exp_px);
        end
        chk("wrap_cnt_zero", {8'd0, o_frame_cnt}, 16'd0);

        // Reset on the last pixel of a frame: no frame done, back to mode 0
        for (int p = 0; p < 63; p++) step(1'b0, 1'b1, 16'h0010);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        i_pixel_valid = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        i_pixel_valid = 1'b0;
        @(negedge clk);
        chk("midrst_bg", bg_data, 16'h001F);
        chk("midrst_cnt", {8'd0, o_frame_cnt}, 16'd0);
        step(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("midrst_no_done", 16'(done_cnt), 16'd2);
        i_mode = 2'd1;
        step(1'b0, 1'b1, 16'h001F);
        step(1'b0, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        chk("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/background_pattern_gen.md
BACKGROUND_PATTERN_GEN -- requirements
Module: background_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter SOLID_COLOR, default 16'h001F, meaning the RGB565 colour for mode 0.
REQ-004 SHALL have parameter CHK_BIT, default 5, meaning the coordinate bit that selects the checkerboard tile.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_frame_start, input, 1 bit: one-cycle pulse that marks the start of a new frame.
REQ-008 SHALL have port i_pixel_valid, input, 1 bit: the mixer consumes the current bg_data in this cycle.
REQ-009 SHALL have port i_mode, input, 2 bits: pattern select (0 solid, 1 colour bars, 2 checkerboard, 3 scrolling gradient).
REQ-010 SHALL have port bg_data, output, 16 bits: registered RGB565 background pixel for the current position.
REQ-011 SHALL have port o_frame_done, output, 1 bit: registered one-cycle pulse after the last pixel of a frame is consumed.
REQ-012 SHALL have port o_frame_cnt, output, 8 bits: count of frame starts, wrapping.

Function
REQ-013 SHALL keep x (10 bits) and y (9 bits), the position of the next pixel to be consumed.
REQ-014 SHALL present bg_data for position (x,y) before the cycle that consumes it, so bg_data is valid in the same cycle as i_pixel_valid with zero added latency.
REQ-015 SHALL, when i_pixel_valid=1 and i_frame_start=0, advance the position one step: x+1; at x=H_ACTIVE-1, x wraps to 0 and y increments; at (H_ACTIVE-1,V_ACTIVE-1), both x and y wrap to 0.
REQ-016 SHALL, when i_pixel_valid=0, hold x, y and bg_data.
REQ-017 SHALL, on i_frame_start=1, do four things: set x=y=0, latch i_mode into mode_q, increment o_frame_cnt modulo 256, and load bg_data with the (0,0) pixel of the newly latched mode.
REQ-018 SHALL give i_frame_start priority when it coincides with i_pixel_valid; the valid in that cycle does not advance the position.
REQ-019 SHALL take the pattern only from mode_q; changes on i_mode between frame starts have no effect.
REQ-020 SHALL pulse o_frame_done for one cycle, in the cycle after a consumed pixel at (H_ACTIVE-1,V_ACTIVE-1); otherwise o_frame_done=0.
REQ-021 SHALL compute the next bg_data from the next (x,y) and register it, so output is glitch-free.
REQ-022 SHALL, in mode 0, output SOLID_COLOR.
REQ-023 SHALL, in mode 1, use bar index = x / (H_ACTIVE/8), tracked with a bar-pixel counter and a 3-bit bar counter and no divider; both counters reset with x.
REQ-024 SHALL, in mode 1, map bars 0..7 to FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-025 SHALL, in mode 2, output FFFF when x[CHK_BIT] XOR y[CHK_BIT] is 1, else 0000.
REQ-026 SHALL, in mode 3, output R = (x[8:4] + frame_cnt[4:0]) mod 32, G = y[8:3], B = 5'h10, packed as {R,G,B}.
REQ-027 SHALL apply no saturation; all sums wrap to the field width.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set x=0, y=0, bar counters 0, mode_q=0, o_frame_cnt=0, o_frame_done=0, bg_data=SOLID_COLOR.
REQ-029 SHALL give rst priority over i_frame_start and i_pixel_valid; reset mid-frame abandons the frame and emits no o_frame_done.
REQ-030 SHALL, after reset, hold mode 0 until the first i_frame_start.

Verification (H_ACTIVE=16, V_ACTIVE=4, CHK_BIT=1)
REQ-031 SHALL pass this reset case: rst high for 2 cycles, then release -> bg_data=001F, o_frame_cnt=0, o_frame_done=0.
REQ-032 SHALL pass this colour-bar case: i_mode=1, frame_start, then 16 contiguous valids -> bg_data sequence FFFF,FFFF,FFE0,FFE0,07FF,... ends 0000,0000; y becomes 1.
REQ-033 SHALL pass this frame-done case: i_mode=2, frame_start, 64 valids with random gaps -> o_frame_done pulses exactly once, the cycle after valid 64; x=y=0; the checker pattern toggles every 2 pixels and every 2 lines.
REQ-034 SHALL pass this mode-latch case: i_mode changes 1->3 mid-frame -> output remains bars until the next frame_start, then gradient with R at (0,0) = o_frame_cnt[4:0].
REQ-035 SHALL pass this collision case: frame_start coincident with valid at (5,2) -> position becomes (0,0), not (1,0); o_frame_cnt increments by 1; no o_frame_done.
REQ-036 SHALL pass this wrap case: 256 frame_starts -> o_frame_cnt returns to 0; in mode 3 the R channel wraps from 31 to 0.
